// File: rtl/amba3_apb_sram_slave_if.sv
//-----------------------------------------------------------------------------
// amba3_apb_sram_slave_if
//
// APB3 bus bundle between one requester and one completer. Clock and reset
// are not carried here; they stay plain ports on the modules that use them.
//
// Signals:
//   psel     requester -> completer  slave select
//   penable  requester -> completer  access-phase marker
//   pwrite   requester -> completer  1 = write, 0 = read
//   paddr    requester -> completer  byte address
//   pwdata   requester -> completer  write data
//   prdata   completer -> requester  read data
//   pready   completer -> requester  transfer completes this cycle
//   pslverr  completer -> requester  error response (qualified by pready)
//-----------------------------------------------------------------------------
interface amba3_apb_sram_slave_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
);
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDR_BITS-1:0] paddr;
    logic [DATA_BITS-1:0] pwdata;
    logic [DATA_BITS-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/amba3_apb_sram_slave.sv
//-----------------------------------------------------------------------------
// amba3_apb_sram_slave
//
// AMBA 3 APB completer backed by a word-addressed register array. Each
// transfer is accepted on the setup edge (address, direction and error status
// latched, read data fetched), then held in the access phase for WAIT_STATES
// cycles with pready low before completing. Out-of-range or misaligned
// accesses complete with pslverr, never modify memory and read as zero.
//
// Ports:
//   pclk       in   APB clock, all state on rising edge
//   preset_n   in   asynchronous active-low reset
//   apb        slave modport of amba3_apb_sram_slave_if (APB3 bus)
//   err_count  out  saturating count of completed error transfers
//-----------------------------------------------------------------------------
module amba3_apb_sram_slave #(
    parameter int ADDR_BITS   = 32,
    parameter int DATA_BITS   = 32,   // 8, 16, 32 or 64
    parameter int MEM_DEPTH   = 1024, // words of DATA_BITS
    parameter int WAIT_STATES = 0     // 0..15
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    amba3_apb_sram_slave_if.slave   apb,
    output logic [15:0]             err_count
);

    localparam int DATA_BASE = $clog2(DATA_BITS / 8);
    localparam int IDX_BITS  = ADDR_BITS - DATA_BASE;
    localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int WCNT_BITS = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    localparam logic [WCNT_BITS-1:0] WAIT_LOAD = WCNT_BITS'(WAIT_STATES);
    // One bit wider than the word index so MEM_DEPTH itself is representable.
    localparam logic [IDX_BITS:0]    DEPTH_LIM = (IDX_BITS + 1)'(MEM_DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic                 pwrite_q;
    logic                 err_q;
    logic [MEM_AW-1:0]    idx_q;
    logic [WCNT_BITS-1:0] wait_cnt;
    logic [DATA_BITS-1:0] rd_q;

    logic [DATA_BITS-1:0] mem [MEM_DEPTH];

    // FSM strobes
    logic setup_acc;   // setup phase sampled in IDLE
    logic complete;    // access phase completes on this edge
    logic wait_dec;    // access phase held, count down one wait state

    //-------------------------------------------------------------------------
    // Address decode (setup phase)
    //-------------------------------------------------------------------------
    logic [IDX_BITS-1:0] word_idx;
    logic [MEM_AW-1:0]   mem_addr;
    logic                out_of_range;
    logic                misaligned;
    logic                addr_err;

    assign word_idx     = apb.paddr[ADDR_BITS-1:DATA_BASE];
    assign mem_addr     = word_idx[MEM_AW-1:0];
    // Full-width compare: any set upper address bit is an error, never an alias.
    assign out_of_range = {1'b0, word_idx} >= DEPTH_LIM;

    generate
        if (DATA_BASE == 0) begin : g_byte_bus
            assign misaligned = 1'b0;
        end else begin : g_word_bus
            assign misaligned = |apb.paddr[DATA_BASE-1:0];
        end
    endgenerate

    assign addr_err = out_of_range | misaligned;

    //-------------------------------------------------------------------------
    // FSM
    //-------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: every clocked register uses <= so all flops sample the
            // pre-edge values; a blocking = here would create order-dependent
            // races between always_ff blocks.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves a signal unassigned, which would infer a latch.
        state_d   = state_q;
        setup_acc = 1'b0;
        complete  = 1'b0;
        wait_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    setup_acc = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (apb.psel && apb.penable) begin
                    if (wait_cnt == '0) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        wait_dec = 1'b1;
                    end
                end else begin
                    // Requester dropped psel/penable mid-access: abandon the
                    // transfer silently (no write, no error count).
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    //-------------------------------------------------------------------------
    // Transfer context, wait counter, read data and error counter
    //-------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pwrite_q  <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wait_cnt  <= '0;
            rd_q      <= '0;
            err_count <= '0;
        end else begin
            if (setup_acc) begin
                pwrite_q <= apb.pwrite;
                err_q    <= addr_err;
                idx_q    <= mem_addr;
                wait_cnt <= WAIT_LOAD;
                // Fetch at setup so read data is a register output in the
                // access phase; a write completing the cycle before is
                // already in the array by this edge.
                rd_q     <= addr_err ? '0 : mem[mem_addr];
            end else if (wait_dec) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            if (complete && err_q && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    //-------------------------------------------------------------------------
    // Storage array
    //-------------------------------------------------------------------------
    // NOTE: the array has no reset on purpose; clearing it would need a
    // per-word reset fan-out and kill RAM inference. Contents stay undefined
    // until written. A reset mid-transfer still blocks the write because
    // `complete` is decoded from the asynchronously reset state register.
    always_ff @(posedge pclk) begin
        if (complete && pwrite_q && !err_q) begin
            mem[idx_q] <= apb.pwdata;
        end
    end

    //-------------------------------------------------------------------------
    // Bus outputs: decoded only from registers, no input-to-output path
    //-------------------------------------------------------------------------
    logic pready_w;

    assign pready_w    = (state_q == ST_ACCESS) && (wait_cnt == '0);
    assign apb.pready  = pready_w;
    assign apb.pslverr = pready_w && err_q;
    assign apb.prdata  = (pready_w && !pwrite_q) ? rd_q : '0;

endmodule

// File: tb/tb_amba3_apb_sram_slave.sv
//-----------------------------------------------------------------------------
// tb_amba3_apb_sram_slave
//
// Directed bench for amba3_apb_sram_slave. Two instances share one set of
// requester signals: u_ws0 (WAIT_STATES=0) and u_ws3 (WAIT_STATES=3);
// `target` picks which one receives psel/penable and whose responses are read.
//-----------------------------------------------------------------------------
module tb_amba3_apb_sram_slave;

    logic pclk = 1'b0;
    logic preset_n;

    always #5 pclk = ~pclk;

    // Shared requester drive
    logic        psel_r;
    logic        penable_r;
    logic        pwrite_r;
    logic [31:0] paddr_r;
    logic [31:0] pwdata_r;
    logic        target;

    logic [15:0] err_count0;
    logic [15:0] err_count1;

    amba3_apb_sram_slave_if #(.ADDR_BITS(32), .DATA_BITS(32)) bus0 ();
    amba3_apb_sram_slave_if #(.ADDR_BITS(32), .DATA_BITS(32)) bus1 ();

    assign bus0.psel    = psel_r & ~target;
    assign bus0.penable = penable_r & ~target;
    assign bus0.pwrite  = pwrite_r;
    assign bus0.paddr   = paddr_r;
    assign bus0.pwdata  = pwdata_r;

    assign bus1.psel    = psel_r & target;
    assign bus1.penable = penable_r & target;
    assign bus1.pwrite  = pwrite_r;
    assign bus1.paddr   = paddr_r;
    assign bus1.pwdata  = pwdata_r;

    amba3_apb_sram_slave #(
        .ADDR_BITS(32), .DATA_BITS(32), .MEM_DEPTH(1024), .WAIT_STATES(0)
    ) u_ws0 (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .apb       (bus0.slave),
        .err_count (err_count0)
    );

    amba3_apb_sram_slave #(
        .ADDR_BITS(32), .DATA_BITS(32), .MEM_DEPTH(1024), .WAIT_STATES(3)
    ) u_ws3 (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .apb       (bus1.slave),
        .err_count (err_count1)
    );

    logic        pready_m;
    logic        pslverr_m;
    logic [31:0] prdata_m;

    assign pready_m  = target ? bus1.pready  : bus0.pready;
    assign pslverr_m = target ? bus1.pslverr : bus0.pslverr;
    assign prdata_m  = target ? bus1.prdata  : bus0.prdata;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One APB transfer to the selected target. Returns at the falling edge of
    // the cycle in which pready is high, leaving psel asserted so a following
    // call produces a back-to-back setup.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int waits);
        @(posedge pclk); #1;
        psel_r    = 1'b1;
        penable_r = 1'b0;
        pwrite_r  = wr;
        paddr_r   = addr;
        pwdata_r  = wd;
        @(negedge pclk);
        check("pready_in_setup", 32'(pready_m), 32'd0);
        @(posedge pclk); #1;
        penable_r = 1'b1;
        waits = 0;
        @(negedge pclk);
        while (!pready_m && waits < 40) begin
            waits++;
            @(negedge pclk);
        end
        if (!pready_m) check("pready_timeout", 32'(pready_m), 32'd1);
        rd  = prdata_m;
        err = pslverr_m;
    endtask

    task automatic xfer_chk(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_rd,
                            input logic exp_err, input int exp_waits);
        logic [31:0] rd;
        logic        err;
        int          waits;
        xfer(wr, addr, wd, rd, err, waits);
        check({tag, "_prdata"},  rd,          exp_rd);
        check({tag, "_pslverr"}, 32'(err),    32'(exp_err));
        check({tag, "_waits"},   32'(waits),  32'(exp_waits));
    endtask

    // Release the bus for n cycles after a completion edge (n=0: no gap).
    task automatic idle(input int n);
        if (n > 0) begin
            @(posedge pclk); #1;
            psel_r    = 1'b0;
            penable_r = 1'b0;
            repeat (n - 1) @(posedge pclk);
        end
    endtask

    // Drive a transfer on the WAIT_STATES=3 target up to its pready-high
    // cycle, then assert reset between clock edges.
    task automatic rst_mid(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd);
        @(posedge pclk); #1;
        psel_r    = 1'b1;
        penable_r = 1'b0;
        pwrite_r  = wr;
        paddr_r   = addr;
        pwdata_r  = wd;
        @(posedge pclk); #1;
        penable_r = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check({tag, "_pre_pready"}, 32'(pready_m), 32'd1);
        #1 preset_n = 1'b0;
        #1;
    endtask

    task automatic rst_release();
        psel_r    = 1'b0;
        penable_r = 1'b0;
        @(posedge pclk); #1;
        preset_n = 1'b1;
    endtask

    // Scoreboard for the random phase
    logic [31:0] sb      [1024];
    bit          written [1024];
    int          order [$];

    initial begin
        logic [31:0] rd;
        logic        err;
        int          waits;

        preset_n  = 1'b0;
        psel_r    = 1'b0;
        penable_r = 1'b0;
        pwrite_r  = 1'b0;
        paddr_r   = '0;
        pwdata_r  = '0;
        target    = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_pready0",  32'(bus0.pready),  32'd0);
        check("rst_pslverr0", 32'(bus0.pslverr), 32'd0);
        check("rst_prdata0",  bus0.prdata,       32'd0);
        check("rst_errcnt0",  32'(err_count0),   32'd0);
        check("rst_pready1",  32'(bus1.pready),  32'd0);
        check("rst_errcnt1",  32'(err_count1),   32'd0);
        @(posedge pclk); #1;
        preset_n = 1'b1;

        // ---------------- WAIT_STATES=0 ----------------
        target = 1'b0;
        xfer_chk("w40",   1'b1, 32'h0000_0040, 32'h8000_3333, 32'h0, 1'b0, 0);
        xfer_chk("r40",   1'b0, 32'h0000_0040, 32'h0,         32'h8000_3333, 1'b0, 0);
        idle(1);
        xfer_chk("wffc",  1'b1, 32'h0000_0FFC, 32'h1234_5678, 32'h0, 1'b0, 0);
        xfer_chk("w1000", 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b1, 0);
        xfer_chk("r1000", 1'b0, 32'h0000_1000, 32'h0,         32'h0, 1'b1, 0);
        idle(1);
        @(negedge pclk);
        check("errcnt_after_boundary", 32'(err_count0), 32'd2);
        xfer_chk("rffc",  1'b0, 32'h0000_0FFC, 32'h0, 32'h1234_5678, 1'b0, 0);
        xfer_chk("r42",   1'b0, 32'h0000_0042, 32'h0, 32'h0, 1'b1, 0);
        xfer_chk("w41",   1'b1, 32'h0000_0041, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
        xfer_chk("r40b",  1'b0, 32'h0000_0040, 32'h0, 32'h8000_3333, 1'b0, 0);
        xfer_chk("alias", 1'b0, 32'h8000_0040, 32'h0, 32'h0, 1'b1, 0);
        idle(1);
        @(negedge pclk);
        check("errcnt_ws0", 32'(err_count0), 32'd5);

        // ---------------- WAIT_STATES=3 ----------------
        target = 1'b1;
        xfer_chk("w84",      1'b1, 32'h0000_0084, 32'h0440_0011, 32'h0, 1'b0, 3);
        xfer_chk("r84",      1'b0, 32'h0000_0084, 32'h0, 32'h0440_0011, 1'b0, 3);
        xfer_chk("w18",      1'b1, 32'h0000_0018, 32'h1111_1111, 32'h0, 1'b0, 3);
        xfer_chk("w1000_ws3", 1'b1, 32'h0000_1000, 32'h5555_5555, 32'h0, 1'b1, 3);
        idle(1);

        // Abort: psel dropped during a waited access cycle
        @(posedge pclk); #1;
        psel_r    = 1'b1;
        penable_r = 1'b0;
        pwrite_r  = 1'b1;
        paddr_r   = 32'h0000_0018;
        pwdata_r  = 32'h2244_6688;
        @(posedge pclk); #1;
        penable_r = 1'b1;
        @(negedge pclk);
        check("abort_waiting", 32'(pready_m), 32'd0);
        @(posedge pclk); #1;
        psel_r    = 1'b0;
        penable_r = 1'b0;
        @(posedge pclk); #1;
        @(negedge pclk);
        check("abort_idle_pready", 32'(pready_m), 32'd0);
        xfer_chk("r18_after_abort", 1'b0, 32'h0000_0018, 32'h0, 32'h1111_1111, 1'b0, 3);
        idle(1);
        @(negedge pclk);
        check("errcnt_ws3", 32'(err_count1), 32'd1);

        // Reset during a read completion cycle
        rst_mid("rst_rd", 1'b0, 32'h0000_0084, 32'h0);
        check("rst_rd_pready",  32'(pready_m),   32'd0);
        check("rst_rd_pslverr", 32'(pslverr_m),  32'd0);
        check("rst_rd_prdata",  prdata_m,        32'd0);
        check("rst_rd_errcnt1", 32'(err_count1), 32'd0);
        check("rst_rd_errcnt0", 32'(err_count0), 32'd0);
        rst_release();

        // Reset during an erroneous transfer's completion cycle
        rst_mid("rst_err", 1'b1, 32'h0000_1000, 32'h0);
        check("rst_err_pslverr", 32'(pslverr_m), 32'd0);
        rst_release();

        // Reset during a write completion cycle: the write must not land
        rst_mid("rst_wr", 1'b1, 32'h0000_0018, 32'h9999_9999);
        check("rst_wr_pready", 32'(pready_m), 32'd0);
        rst_release();
        xfer(1'b0, 32'h0000_0018, 32'h0, rd, err, waits);
        check("rst_wr_dropped", 32'(rd != 32'h9999_9999), 32'd1);
        idle(1);

        // ---------------- random writes then shuffled reads ----------------
        target = 1'b0;
        for (int i = 0; i < 1024; i++) written[i] = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            int          word;
            logic [31:0] data;
            word = int'($urandom_range(0, 1023));
            data = $urandom;
            xfer(1'b1, 32'(word) << 2, data, rd, err, waits);
            check("rand_wr_pslverr", 32'(err), 32'd0);
            sb[word] = data;
            if (!written[word]) begin
                written[word] = 1'b1;
                order.push_back(word);
            end
            idle(int'($urandom_range(0, 3)));
        end
        for (int i = order.size() - 1; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        foreach (order[k]) begin
            xfer(1'b0, 32'(order[k]) << 2, 32'h0, rd, err, waits);
            check("rand_rd_data",    rd,       sb[order[k]]);
            check("rand_rd_pslverr", 32'(err), 32'd0);
        end
        idle(1);
        @(negedge pclk);
        check("rand_errcnt", 32'(err_count0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
